// File: rtl/img_uart_sender.sv
// img_uart_sender: streams a frame BRAM out over an 8N1 UART line, one pixel per frame
module img_uart_sender #(
  parameter int CLOCKS_PER_BAUD = 50,
  parameter int NUM_PIXELS = 16384,
  parameter int ADDR_WIDTH = 14,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  output logic [ADDR_WIDTH-1:0] bram_addr_out,
  input  logic [7:0]            bram_data_in,
  output logic                  tx_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [ADDR_WIDTH:0]   pixel_count_out
);
  localparam int BW = $clog2(CLOCKS_PER_BAUD);
  localparam int FW = $clog2(READ_LATENCY) + 1;
  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0] bit_q, bit_d;
  logic [FW-1:0] fetch_q, fetch_d;
  logic [7:0] shift_q, shift_d;
  logic tx_q, tx_d;
  logic last_pixel;
  assign last_pixel = addr_q == ADDR_WIDTH'(NUM_PIXELS - 1);
  assign bram_addr_out = addr_q;
  assign pixel_count_out = cnt_q;
  assign tx_out = tx_q;
  assign busy_out = (state_q == FETCH) || (state_q == SEND);
  assign done_out = state_q == DONE;
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      addr_q <= '0;
      cnt_q <= '0;
      baud_q <= '0;
      bit_q <= '0;
      fetch_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      fetch_q <= fetch_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    baud_d = baud_q;
    bit_d = bit_q;
    fetch_d = fetch_q;
    shift_d = shift_q;
    tx_d = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (start_in) begin
          addr_d = '0;
          cnt_d = '0;
          fetch_d = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        fetch_d = fetch_q + 1'b1;
        if (fetch_q == FW'(READ_LATENCY - 1)) begin
          shift_d = bram_data_in;
          fetch_d = '0;
          baud_d = '0;
          bit_d = '0;
          tx_d = 1'b0;
          state_d = SEND;
        end
      end
      SEND: begin
        baud_d = baud_q + 1'b1;
        if (baud_q == BW'(CLOCKS_PER_BAUD - 1)) begin
          baud_d = '0;
          bit_d = bit_q + 4'd1;
          tx_d = (bit_q == 4'd8) ? 1'b1 : shift_q[bit_q[2:0]];
          if (bit_q == 4'd9) begin
            bit_d = '0;
            tx_d = 1'b1;
            cnt_d = cnt_q + 1'b1;
            addr_d = last_pixel ? addr_q : addr_q + 1'b1;
            state_d = last_pixel ? DONE : FETCH;
          end
        end
      end
      DONE: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_img_uart_sender.sv
// tb_img_uart_sender: randomized image transfers checked cycle-by-cycle against a frame-timing model
module tb_img_uart_sender;
  localparam int C = 4;
  localparam int NP = 4;
  localparam int AW = 3;
  localparam int RL = 2;
  localparam int PER = RL + 10 * C;
  localparam int LAST = NP * PER + 1;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic start_in = 1'b0;
  logic [AW-1:0] bram_addr_out;
  logic [7:0] bram_data_in;
  logic tx_out, busy_out, done_out;
  logic [AW:0] pixel_count_out;
  logic [7:0] mem [2**AW];
  logic [7:0] rd_q;
  int tests = 0;
  int fails = 0;
  img_uart_sender #(.CLOCKS_PER_BAUD(C), .NUM_PIXELS(NP), .ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .start_in(start_in),
    .bram_addr_out(bram_addr_out),
    .bram_data_in(bram_data_in),
    .tx_out(tx_out),
    .busy_out(busy_out),
    .done_out(done_out),
    .pixel_count_out(pixel_count_out)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) rd_q <= mem[bram_addr_out];
  assign bram_data_in = rd_q;
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input int t, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s t=%0d: got %0h want %0h", tag, t, got, want);
    end
  endtask
  function automatic logic model_tx(input int t);
    int p, o, b;
    p = (t - 1) / PER;
    o = (t - 1) % PER;
    if (p >= NP || o < RL) return 1'b1;
    b = (o - RL) / C;
    return b == 0 ? 1'b0 : b == 9 ? 1'b1 : mem[p][b-1];
  endfunction
  task automatic chk_idle(input string tag, input int t, input int cnt, input int addr);
    chk({tag, "_tx"}, t, 32'(tx_out), 32'd1);
    chk({tag, "_busy"}, t, 32'(busy_out), 32'd0);
    chk({tag, "_done"}, t, 32'(done_out), 32'd0);
    chk({tag, "_cnt"}, t, 32'(pixel_count_out), 32'(cnt));
    chk({tag, "_addr"}, t, 32'(bram_addr_out), 32'(addr));
  endtask
  task automatic xfer(input int abort_t, input bit pokes);
    int p;
    for (int i = 0; i < NP; i++) mem[i] = 8'($urandom);
    @(negedge clk_in);
    start_in = 1'b1;
    for (int t = 1; t <= LAST; t++) begin
      @(negedge clk_in);
      if (!rst_in) begin
        chk_idle("rst_mid", t, 0, 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk_in);
          chk_idle("after_rst", j, 0, 0);
        end
        return;
      end
      start_in = pokes && (t == PER + 5 || t == LAST);
      p = (t - 1) / PER;
      chk("tx", t, 32'(tx_out), 32'(model_tx(t)));
      chk("busy", t, 32'(busy_out), 32'(t < LAST));
      chk("done", t, 32'(done_out), 32'(t == LAST));
      chk("addr", t, 32'(bram_addr_out), 32'(p < NP ? p : NP - 1));
      chk("cnt", t, 32'(pixel_count_out), 32'(p < NP ? p : NP));
      if (t == abort_t) rst_in = 1'b0;
    end
    if (!pokes) begin
      @(negedge clk_in);
      chk_idle("post", LAST + 1, NP, NP - 1);
    end
  endtask
  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      chk_idle("reset", i, 0, 0);
      start_in = ~start_in;
    end
    @(negedge clk_in);
    chk_idle("reset", 3, 0, 0);
    rst_in = 1'b1;
    start_in = 1'b0;
    @(negedge clk_in);
    chk_idle("released", 0, 0, 0);
    xfer(0, 1'b0);
    xfer(0, 1'b1);
    xfer(0, 1'b0);
    xfer(2 * PER + RL + 4 * C + 1, 1'b0);
    xfer(0, 1'b0);
    for (int n = 0; n < 3; n++) xfer(0, 1'(n == 0 ? 0 : $urandom_range(0, 1)));
    xfer(0, 1'b0);
    start_in = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/img_uart_sender.md
# img_uart_sender

Streams a stored greyscale image out of a frame BRAM over a UART line, one 8-bit pixel per frame, from address 0 upward. It sits on the read port of the image BRAM that the UART image loader fills. It is the transmit-side counterpart to that loader: on a start pulse it reads every pixel, serialises it (8N1, LSB first) and reports completion. It contains its own bit serialiser, so no separate transmitter is instantiated alongside it.

## Interface
Parameters:
- CLOCKS_PER_BAUD, 50, clock cycles per UART bit; must be ≥ 2.
- NUM_PIXELS, 16384, pixels per image (128×128).
- ADDR_WIDTH, 14, BRAM address width; NUM_PIXELS ≤ 2**ADDR_WIDTH.
- READ_LATENCY, 2, BRAM read latency in cycles; must be ≥ 1.

Ports:
- clk_in  input  1  system clock; everything is on its rising edge.
- rst_in  input  1  reset, synchronous and active-low.
- start_in  input  1  one-cycle request to send the whole image; only acted on in IDLE.
- bram_addr_out  output  ADDR_WIDTH  read address to the BRAM read port.
- bram_data_in  input  8  BRAM read data, valid READ_LATENCY cycles after the address.
- tx_out  output  1  UART serial line, idle high.
- busy_out  output  1  high from acceptance of start_in until transfer end.
- done_out  output  1  one-cycle pulse after the last stop bit of the last pixel.
- pixel_count_out  output  ADDR_WIDTH+1  number of pixels fully transmitted in the current or last transfer.

## Operation
- Reset values (rst_in low at a clock edge):
  - state IDLE
  - tx_out=1, busy_out=0, done_out=0
  - bram_addr_out=0, pixel_count_out=0
  - baud counter and bit index 0
- States:
  - IDLE: tx_out=1. If start_in=1, then addr←0, pixel_count_out←0, go to FETCH.
  - FETCH: hold bram_addr_out stable for exactly READ_LATENCY cycles. On the last FETCH cycle, load shift_reg←bram_data_in and go to SEND.
  - SEND: transmit 10 bits, each for exactly CLOCKS_PER_BAUD cycles: start bit 0, data[0]…data[7], stop bit 1. At the end of the stop bit, pixel_count_out increments.
    - If addr==NUM_PIXELS-1, go to DONE.
    - Otherwise addr←addr+1 and go to FETCH.
  - DONE: done_out=1 for this single cycle, busy_out=0, go to IDLE.
- tx_out is registered (driven from a flop, not combinational logic). bram_addr_out changes only on the FETCH entry edge.
- start_in is ignored outside IDLE. This includes the DONE cycle: a start in DONE is dropped, and a new start is accepted from the IDLE cycle onward.
- Image data is never modified. Addresses above NUM_PIXELS-1 are never issued.
- Reset mid-transfer: on the edge where rst_in is low, all outputs take their reset values. The partial frame is truncated with the line high, no done_out is issued, and the block waits for a fresh start_in.
- Counter widths:
  - baud counter spans 0..CLOCKS_PER_BAUD-1.
  - bit index spans 0..9.
  - pixel_count_out saturates naturally at NUM_PIXELS; no wrap occurs because ADDR_WIDTH+1 bits hold NUM_PIXELS.

## Timing
- start_in high at edge k: busy_out=1 and bram_addr_out=0 from k+1. FETCH occupies cycles k+1..k+READ_LATENCY.
- The start bit (tx_out=0) begins at cycle k+READ_LATENCY+1.
- Per-pixel period: READ_LATENCY + 10·CLOCKS_PER_BAUD cycles, with no gaps beyond the FETCH cycles. The stop bit of pixel n is followed directly by the FETCH of pixel n+1, with tx_out held high.
- Total transfer: done_out fires at cycle k + NUM_PIXELS·(READ_LATENCY+10·CLOCKS_PER_BAUD) + 1. busy_out falls in that same cycle.
- Bit j of a frame (j=0 start, 1..8 data, 9 stop) occupies cycles s+j·CLOCKS_PER_BAUD … s+(j+1)·CLOCKS_PER_BAUD−1, where s is the first cycle of the start bit.

## Test plan
- Reset: hold rst_in=0 for 3 cycles with start_in toggling → tx_out=1, busy_out=0, done_out=0, pixel_count_out=0 throughout and after release.
- Single pixel, NUM_PIXELS=1, CLOCKS_PER_BAUD=4, READ_LATENCY=2, BRAM[0]=8'hA5, start at edge k → tx_out sequence from k+3 is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles long. done_out pulses once at k+43, and pixel_count_out=1.
- Ramp image, NUM_PIXELS=4, CLOCKS_PER_BAUD=4, BRAM[i]=i+8'h10, checked with a UART-decoding monitor → bytes 10,11,12,13 in order. bram_addr_out steps 0→3 and never reaches 4, and there are exactly 42 cycles between successive start-bit falling edges.
- start_in pulsed mid-transfer and again during the DONE cycle → no restart and no address reset. Only one done_out pulse, and a start one cycle after DONE begins a new transfer from address 0.
- rst_in=0 during data bit 3 of pixel 2 → tx_out=1 on the next cycle, busy_out=0, no done_out. A following start re-sends from pixel 0.
- Default parameters, full 16384-pixel image → done_out exactly 16384·502+1 cycles after start, with all bytes matching BRAM contents.
